// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART packet dispatcher.
package uart_pkg;

  // Dispatcher framing states, in packet byte order.
  typedef enum logic [2:0] {
    SYNC,
    DEST,
    LEN,
    PAYLOAD,
    CSUM
  } disp_state_t;

  localparam logic [7:0] UART_SYNC_DEFAULT = 8'hA5;

  // Modulo-256 accumulate used for the packet checksum.
  function automatic logic [7:0] csum8(input logic [7:0] a, input logic [7:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/uart_dispatch_obuf.sv
// One-entry valid/ready output register. Holds one payload byte plus its
// last flag and presents it on the one-hot valid bit of its destination.
// The destination is captured with the byte, so a byte left behind by an
// aborted packet still goes to the consumer it was meant for.
module uart_dispatch_obuf #(
  parameter int NUM_DEST = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_load,
  input  logic [7:0]          i_data,
  input  logic                i_last,
  input  logic [3:0]          i_dest,
  input  logic [NUM_DEST-1:0] i_ready,
  output logic [NUM_DEST-1:0] o_valid,
  output logic [7:0]          o_data,
  output logic                o_last,
  output logic                o_can_load
);

  logic [NUM_DEST-1:0] r_valid;
  logic [7:0]          r_data;
  logic                r_last;
  logic [NUM_DEST-1:0] w_dest_oh;
  logic                w_drain;

  // Decode the destination index into its one-hot valid pattern.
  always_comb begin
    w_dest_oh = '0;
    for (int d = 0; d < NUM_DEST; d++) begin
      w_dest_oh[d] = (i_dest == 4'(d));
    end
  end

  assign w_drain    = |(r_valid & i_ready);
  // A drain and a load in the same cycle keep one byte per clock flowing.
  assign o_can_load = ~(|r_valid) | w_drain;

  // Buffer register: load wins over drain, drain alone empties the entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
      r_data  <= 8'h00;
      r_last  <= 1'b0;
    end else if (i_load) begin
      r_valid <= w_dest_oh;
      r_data  <= i_data;
      r_last  <= i_last;
    end else if (w_drain) begin
      r_valid <= '0;
      r_last  <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_last  = r_last;

endmodule

// File: rtl/uart_rx_dispatcher.sv
// Packet framer behind the UART receiver: SYNC, DEST, LEN, PAYLOAD[LEN], CSUM.
// Payload bytes are cut through to the addressed consumer; completion and
// error status are reported as one-cycle pulses.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   SYNC    | hunting for SYNC_BYTE, other bytes discarded
//   DEST    | capture destination, flag drop if out of range
//   LEN     | capture payload length, zero length skips to CSUM
//   PAYLOAD | forward bytes to the output buffer (or swallow if dropping)
//   CSUM    | check running sum, pulse the packet outcome
module uart_rx_dispatcher
  import uart_pkg::*;
#(
  parameter int         NUM_DEST     = 4,
  parameter logic [7:0] SYNC_BYTE    = UART_SYNC_DEFAULT,
  parameter int         TIMEOUT_CLKS = 50000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [7:0]          out_data,
  output logic [NUM_DEST-1:0] out_valid,
  input  logic [NUM_DEST-1:0] out_ready,
  output logic                out_last,
  output logic                pkt_done,
  output logic                err_csum,
  output logic                err_dest,
  output logic                err_timeout
);

  localparam int TW = $clog2(TIMEOUT_CLKS + 1);

  disp_state_t r_state;
  logic [3:0]  r_dest;
  logic        r_drop;
  logic [7:0]  r_sum;
  logic [7:0]  r_remaining;
  logic [TW-1:0] r_tmo_cnt;
  logic        r_pkt_done;
  logic        r_err_csum;
  logic        r_err_dest;
  logic        r_err_timeout;

  logic        w_in_ready;
  logic        w_accept;
  logic        w_load;
  logic        w_can_load;

  // Only PAYLOAD can stall, and only when the buffer cannot take the byte.
  always_comb begin
    w_in_ready = 1'b0;
    if (!reset) begin
      if (r_state == PAYLOAD) w_in_ready = r_drop | w_can_load;
      else                    w_in_ready = 1'b1;
    end
  end

  assign w_accept = in_valid & w_in_ready;
  assign w_load   = w_accept & (r_state == PAYLOAD) & ~r_drop;
  assign in_ready = w_in_ready;

  // Framing FSM, running checksum, idle timeout and status pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= SYNC;
      r_dest        <= 4'd0;
      r_drop        <= 1'b0;
      r_sum         <= 8'h00;
      r_remaining   <= 8'h00;
      r_tmo_cnt     <= '0;
      r_pkt_done    <= 1'b0;
      r_err_csum    <= 1'b0;
      r_err_dest    <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_pkt_done    <= 1'b0;
      r_err_csum    <= 1'b0;
      r_err_dest    <= 1'b0;
      r_err_timeout <= 1'b0;
      if (w_accept) begin
        r_tmo_cnt <= '0;
        case (r_state)
          SYNC: begin
            if (in_data == SYNC_BYTE) r_state <= DEST;
          end
          DEST: begin
            r_dest  <= in_data[3:0];
            r_drop  <= (in_data >= 8'(NUM_DEST));
            r_sum   <= in_data;
            r_state <= LEN;
          end
          LEN: begin
            r_remaining <= in_data;
            r_sum       <= csum8(r_sum, in_data);
            r_state     <= (in_data == 8'h00) ? CSUM : PAYLOAD;
          end
          PAYLOAD: begin
            r_sum       <= csum8(r_sum, in_data);
            r_remaining <= r_remaining - 8'd1;
            if (r_remaining == 8'd1) r_state <= CSUM;
          end
          CSUM: begin
            if (r_drop)                              r_err_dest <= 1'b1;
            else if (csum8(r_sum, in_data) == 8'h00) r_pkt_done <= 1'b1;
            else                                     r_err_csum <= 1'b1;
            r_state <= SYNC;
          end
          default: r_state <= SYNC;
        endcase
      end else if (r_state == SYNC) begin
        r_tmo_cnt <= '0;
      end else if (w_in_ready && !in_valid) begin
        // Backpressure stalls never reach here, so they do not age the packet.
        if (r_tmo_cnt == TW'(TIMEOUT_CLKS - 1)) begin
          r_err_timeout <= 1'b1;
          r_state       <= SYNC;
          r_tmo_cnt     <= '0;
        end else begin
          r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
      end
    end
  end

  uart_dispatch_obuf #(
    .NUM_DEST (NUM_DEST)
  ) u_obuf (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_data     (in_data),
    .i_last     (r_remaining == 8'd1),
    .i_dest     (r_dest),
    .i_ready    (out_ready),
    .o_valid    (out_valid),
    .o_data     (out_data),
    .o_last     (out_last),
    .o_can_load (w_can_load)
  );

  assign pkt_done    = r_pkt_done;
  assign err_csum    = r_err_csum;
  assign err_dest    = r_err_dest;
  assign err_timeout = r_err_timeout;

endmodule

// File: tb/tb_uart_rx_dispatcher.sv
// Directed bench for uart_rx_dispatcher: packet vector table plus
// hand-written backpressure, timeout and reset sequences.
module tb_uart_rx_dispatcher;

  localparam int ND  = 4;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    out_data;
  logic [ND-1:0] out_valid;
  logic [ND-1:0] out_ready;
  logic          out_last;
  logic          pkt_done;
  logic          err_csum;
  logic          err_dest;
  logic          err_timeout;

  uart_rx_dispatcher #(
    .NUM_DEST     (ND),
    .SYNC_BYTE    (8'hA5),
    .TIMEOUT_CLKS (TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .pkt_done    (pkt_done),
    .err_csum    (err_csum),
    .err_dest    (err_dest),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               nb;
    logic [0:7][7:0]  b;
    logic [3:0]       oready;
    int               nout;
    logic [0:3][7:0]  d;
    logic [3:0]       voh;
    int               kind;   // 0 pkt_done, 1 err_csum, 2 err_dest
  } vec_t;

  vec_t tv[$];

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] obs_d[$];
  logic [3:0] obs_v[$];
  logic       obs_l[$];
  int c_pkt, c_csum, c_dest, c_tmo;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Observe delivered bytes and pulse widths on the falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (|(out_valid & out_ready)) begin
        obs_d.push_back(out_data);
        obs_v.push_back(out_valid);
        obs_l.push_back(out_last);
      end
      c_pkt  = c_pkt  + int'(pkt_done);
      c_csum = c_csum + int'(err_csum);
      c_dest = c_dest + int'(err_dest);
      c_tmo  = c_tmo  + int'(err_timeout);
      check("onehot0_valid", 32'($onehot0(out_valid)), 32'd1);
    end
  end

  task automatic clear_obs();
    obs_d.delete();
    obs_v.delete();
    obs_l.delete();
    c_pkt = 0; c_csum = 0; c_dest = 0; c_tmo = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int  k;
    bit  rdy;
    in_data  = b;
    in_valid = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      k++;
    end while (!rdy && k < 200);
    in_valid = 1'b0;
    check("byte_accepted", 32'(rdy), 32'd1);
  endtask

  task automatic settle();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input int nb, input logic [0:7][7:0] b, input logic [3:0] oready,
                         input int nout, input logic [0:3][7:0] d, input logic [3:0] voh,
                         input int kind);
    vec_t v;
    v.nb = nb; v.b = b; v.oready = oready; v.nout = nout;
    v.d = d; v.voh = voh; v.kind = kind;
    tv.push_back(v);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = '1;
    clear_obs();

    add_vec(6, {8'hA5, 8'h01, 8'h02, 8'h10, 8'h20, 8'hCD, 8'h00, 8'h00}, 4'hF,
            2, {8'h10, 8'h20, 8'h00, 8'h00}, 4'b0010, 0);
    add_vec(5, {8'hA5, 8'h00, 8'h01, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00}, 4'hF,
            1, {8'h55, 8'h00, 8'h00, 8'h00}, 4'b0001, 1);
    add_vec(6, {8'hA5, 8'h07, 8'h02, 8'hAA, 8'hBB, 8'h9C, 8'h00, 8'h00}, 4'hF,
            0, {8'h00, 8'h00, 8'h00, 8'h00}, 4'b0000, 2);
    add_vec(6, {8'h00, 8'hFF, 8'hA5, 8'h03, 8'h00, 8'hFD, 8'h00, 8'h00}, 4'hF,
            0, {8'h00, 8'h00, 8'h00, 8'h00}, 4'b0000, 0);
    add_vec(7, {8'hA5, 8'h03, 8'h03, 8'hA5, 8'h00, 8'hFF, 8'h56, 8'h00}, 4'hF,
            3, {8'hA5, 8'h00, 8'hFF, 8'h00}, 4'b1000, 0);
    add_vec(5, {8'hA5, 8'h04, 8'h01, 8'h77, 8'h84, 8'h00, 8'h00, 8'h00}, 4'hF,
            0, {8'h00, 8'h00, 8'h00, 8'h00}, 4'b0000, 2);

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  32'(in_ready),  32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_last",  32'(out_last),  32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_pulses",    32'({pkt_done, err_csum, err_dest, err_timeout}), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("sync_in_ready", 32'(in_ready), 32'd1);

    // Table-driven packets.
    for (int i = 0; i < tv.size(); i++) begin
      clear_obs();
      out_ready = tv[i].oready;
      for (int j = 0; j < tv[i].nb; j++) send_byte(tv[i].b[j]);
      settle();
      check($sformatf("v%0d_nout", i), 32'(obs_d.size()), 32'(tv[i].nout));
      for (int k = 0; k < tv[i].nout; k++) begin
        if (k < obs_d.size()) begin
          check($sformatf("v%0d_data%0d", i, k),  32'(obs_d[k]), 32'(tv[i].d[k]));
          check($sformatf("v%0d_valid%0d", i, k), 32'(obs_v[k]), 32'(tv[i].voh));
          check($sformatf("v%0d_last%0d", i, k),  32'(obs_l[k]), 32'(k == tv[i].nout - 1));
        end
      end
      check($sformatf("v%0d_pkt_done", i), 32'(c_pkt),  32'(tv[i].kind == 0));
      check($sformatf("v%0d_err_csum", i), 32'(c_csum), 32'(tv[i].kind == 1));
      check($sformatf("v%0d_err_dest", i), 32'(c_dest), 32'(tv[i].kind == 2));
      check($sformatf("v%0d_err_tmo", i),  32'(c_tmo),  32'd0);
    end

    // Backpressure: hold destination 1 off longer than the idle timeout.
    clear_obs();
    out_ready = 4'b1101;
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h10);
    in_data  = 8'h20;
    in_valid = 1'b1;
    for (int s = 0; s < TMO + 4; s++) begin
      @(negedge clk);
      check("bp_in_ready",  32'(in_ready),  32'd0);
      check("bp_out_valid", 32'(out_valid), 32'b0010);
      check("bp_out_data",  32'(out_data),  32'h10);
      @(posedge clk);
      #1;
    end
    out_ready = 4'hF;
    send_byte(8'h20);
    send_byte(8'hCD);
    settle();
    check("bp_nout", 32'(obs_d.size()), 32'd2);
    if (obs_d.size() == 2) begin
      check("bp_data0", 32'(obs_d[0]), 32'h10);
      check("bp_last0", 32'(obs_l[0]), 32'd0);
      check("bp_data1", 32'(obs_d[1]), 32'h20);
      check("bp_last1", 32'(obs_l[1]), 32'd1);
    end
    check("bp_pkt_done", 32'(c_pkt), 32'd1);
    check("bp_err_tmo",  32'(c_tmo), 32'd0);

    // Timeout mid-payload, then a fresh packet.
    clear_obs();
    out_ready = 4'hF;
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h11);
    begin
      int n;
      n = 0;
      do begin
        @(posedge clk);
        #1;
        n++;
      end while (!err_timeout && n < TMO + 20);
      check("tmo_latency", 32'(n), 32'(TMO));
    end
    settle();
    check("tmo_nout", 32'(obs_d.size()), 32'd1);
    if (obs_d.size() == 1) begin
      check("tmo_data",  32'(obs_d[0]), 32'h11);
      check("tmo_valid", 32'(obs_v[0]), 32'b0100);
      check("tmo_last",  32'(obs_l[0]), 32'd0);
    end
    check("tmo_pulse",    32'(c_tmo), 32'd1);
    check("tmo_no_pkt",   32'(c_pkt), 32'd0);
    clear_obs();
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'hFE);
    settle();
    check("resync_pkt_done", 32'(c_pkt), 32'd1);
    check("resync_nout",     32'(obs_d.size()), 32'd0);
    check("resync_err_tmo",  32'(c_tmo), 32'd0);

    // Reset with a byte stuck in the buffer mid-payload.
    clear_obs();
    out_ready = 4'h0;
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h03);
    send_byte(8'h10);
    @(negedge clk);
    check("pre_rst_valid", 32'(out_valid), 32'b0010);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_valid",    32'(out_valid), 32'd0);
    check("mid_rst_last",     32'(out_last),  32'd0);
    check("mid_rst_in_ready", 32'(in_ready),  32'd0);
    reset = 1'b0;
    out_ready = 4'hF;
    clear_obs();
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h42);
    send_byte(8'hBD);
    settle();
    check("post_rst_nout", 32'(obs_d.size()), 32'd1);
    if (obs_d.size() == 1) begin
      check("post_rst_data",  32'(obs_d[0]), 32'h42);
      check("post_rst_valid", 32'(obs_v[0]), 32'b0001);
      check("post_rst_last",  32'(obs_l[0]), 32'd1);
    end
    check("post_rst_pkt_done", 32'(c_pkt), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
